// File: rtl/tone_sequencer_if.sv
// Control/status bundle between a game controller and the tone sequencer.
interface tone_sequencer_if;
    logic       start;
    logic [2:0] sel;
    logic       seq_end;
    logic       busy;
    logic       pwm_out;
    logic       amp_en;

    modport master (output start, sel, input seq_end, busy, pwm_out, amp_en);
    modport slave  (input start, sel, output seq_end, busy, pwm_out, amp_en);
endinterface

// File: rtl/tone_sequencer.sv
// Plays short ROM-defined note sequences as a square wave on pwm_out.
// A sequence is a list of {half-period, duration-in-ticks} entries ended by dur 0.
module tone_sequencer #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int DIV_SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    tone_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

    localparam int TW = $clog2(TICK_CYCLES);

    state_t          state;
    logic [2:0]      curSel;
    logic [3:0]      idx;
    logic [TW-1:0]   tick;
    logic [17:0]     phase;
    logic [17:0]     halfEff;
    logic [7:0]      durLeft;
    logic            pwmReg;
    logic            busyReg;
    logic            seqEndReg;

    logic [25:0]     entry;
    logic [17:0]     entryHalf;
    logic [7:0]      entryDur;

    function automatic logic [25:0] romEntry(input logic [2:0] s, input logic [2:0] i);
        case ({s, i})
            6'o10:   romEntry = {18'd113636, 8'd5};
            6'o20:   romEntry = {18'd95556,  8'd10};
            6'o21:   romEntry = {18'd75843,  8'd10};
            6'o22:   romEntry = {18'd63776,  8'd10};
            6'o30:   romEntry = {18'd63776,  8'd15};
            6'o31:   romEntry = {18'd47778,  8'd15};
            6'o40:   romEntry = {18'd127552, 8'd10};
            6'o41:   romEntry = {18'd0,      8'd5};
            6'o42:   romEntry = {18'd191113, 8'd20};
            6'o50:   romEntry = {18'd95556,  8'd10};
            6'o51:   romEntry = {18'd75843,  8'd10};
            6'o52:   romEntry = {18'd63776,  8'd10};
            6'o53:   romEntry = {18'd47778,  8'd30};
            6'o60:   romEntry = {18'd95556,  8'd15};
            6'o61:   romEntry = {18'd127552, 8'd15};
            6'o62:   romEntry = {18'd191113, 8'd40};
            default: romEntry = 26'd0;
        endcase
    endfunction

    assign entry     = romEntry(curSel, idx[2:0]);
    assign entryHalf = entry[25:8];
    assign entryDur  = entry[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            curSel    <= 3'd0;
            idx       <= 4'd0;
            tick      <= '0;
            phase     <= 18'd0;
            halfEff   <= 18'd0;
            durLeft   <= 8'd0;
            pwmReg    <= 1'b0;
            busyReg   <= 1'b0;
            seqEndReg <= 1'b0;
        end else if (bus.start) begin
            // A new request always wins, including preemption of a playing note.
            curSel    <= bus.sel;
            idx       <= 4'd0;
            state     <= LOAD;
            busyReg   <= 1'b1;
            seqEndReg <= 1'b0;
            pwmReg    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (idx[3] || entryDur == 8'd0) begin
                        state     <= DONE;
                        busyReg   <= 1'b0;
                        seqEndReg <= 1'b1;
                    end else begin
                        halfEff <= entryHalf >> DIV_SHIFT;
                        durLeft <= entryDur;
                        tick    <= '0;
                        phase   <= 18'd0;
                        pwmReg  <= 1'b0;
                        state   <= PLAY;
                    end
                end
                PLAY: begin
                    if (halfEff == 18'd0) begin
                        pwmReg <= 1'b0;
                    end else if (phase == halfEff - 18'd1) begin
                        phase  <= 18'd0;
                        pwmReg <= ~pwmReg;
                    end else begin
                        phase <= phase + 18'd1;
                    end
                    // Note end overrides the toggle so LOAD always sees a low output.
                    if (tick == TW'(TICK_CYCLES - 1)) begin
                        tick <= '0;
                        if (durLeft == 8'd1) begin
                            durLeft <= 8'd0;
                            idx     <= idx + 4'd1;
                            pwmReg  <= 1'b0;
                            state   <= LOAD;
                        end else begin
                            durLeft <= durLeft - 8'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busyReg;
    assign bus.amp_en  = busyReg;
    assign bus.seq_end = seqEndReg;
    assign bus.pwm_out = pwmReg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer with TICK_CYCLES=4, DIV_SHIFT=14: per-cycle expected
// outputs are queued when a start is driven and popped as the DUT runs.
module tb_tone_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    tone_sequencer_if bif();

    tone_sequencer #(.TICK_CYCLES(4), .DIV_SHIFT(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic amp;
        logic seqEnd;
        logic pwm;
    } obs_t;

    typedef struct {
        logic [2:0] selA;
        int         preAt;
        logic [2:0] selB;
        int         expEnd;
    } vec_t;

    obs_t expQ[$];
    int   nHalf[8][8];
    int   nDur[8][8];
    vec_t vecs[9];

    function automatic obs_t mk(input logic b, input logic s, input logic p);
        return {b, b, s, p};
    endfunction

    // Expected waveform: LOAD, then per note dur*4 PLAY cycles with
    // pwm = (i / half) odd, a LOAD between notes, then held DONE.
    task automatic pushSeq(input int s, input int limit);
        obs_t tmp[$];
        tmp.push_back(mk(1'b1, 1'b0, 1'b0));
        for (int n = 0; n < 8 && nDur[s][n] != 0; n++) begin
            for (int i = 0; i < nDur[s][n] * 4; i++)
                tmp.push_back(mk(1'b1, 1'b0,
                    (nHalf[s][n] == 0) ? 1'b0 : 1'(((i / nHalf[s][n]) % 2))));
            tmp.push_back(mk(1'b1, 1'b0, 1'b0));
        end
        for (int k = 0; k < 3; k++) tmp.push_back(mk(1'b0, 1'b1, 1'b0));
        for (int k = 0; k < tmp.size() && (limit < 0 || k < limit); k++)
            expQ.push_back(tmp[k]);
    endtask

    task automatic checkCycle(input string name, input obs_t exp);
        obs_t act;
        act = {bif.busy, bif.amp_en, bif.seq_end, bif.pwm_out};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: busy/amp_en/seq_end/pwm_out got %b required %b", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v);
        int j;
        int startJ;
        int firstEnd;
        if (v.preAt > 0) begin
            pushSeq(v.selA, 1 + v.preAt);
            pushSeq(v.selB, -1);
        end else begin
            pushSeq(v.selA, -1);
        end
        @(negedge clk);
        bif.start = 1'b1;
        bif.sel   = v.selA;
        j = 0; startJ = 0; firstEnd = -1;
        while (expQ.size() > 0) begin
            @(negedge clk);
            j++;
            if (bif.seq_end && firstEnd < 0) firstEnd = j - startJ;
            checkCycle($sformatf("sel%0d/%0d cyc%0d", v.selA, v.selB, j), expQ.pop_front());
            if (v.preAt > 0 && j == 1 + v.preAt) begin
                bif.start = 1'b1;
                bif.sel   = v.selB;
                startJ    = j;
            end else begin
                bif.start = 1'b0;
                bif.sel   = 3'($urandom);
            end
        end
        tests++;
        if (firstEnd != v.expEnd) begin
            fails++;
            $display("FAIL seq_end_latency sel%0d/%0d: got %0d required %0d",
                     v.selA, v.selB, firstEnd, v.expEnd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 8; s++)
            for (int n = 0; n < 8; n++) begin
                nHalf[s][n] = 0;
                nDur[s][n]  = 0;
            end
        // Half-periods already shifted right by 14.
        nHalf[1][0] = 6;  nDur[1][0] = 5;
        nHalf[2][0] = 5;  nDur[2][0] = 10;
        nHalf[2][1] = 4;  nDur[2][1] = 10;
        nHalf[2][2] = 3;  nDur[2][2] = 10;
        nHalf[3][0] = 3;  nDur[3][0] = 15;
        nHalf[3][1] = 2;  nDur[3][1] = 15;
        nHalf[4][0] = 7;  nDur[4][0] = 10;
        nHalf[4][1] = 0;  nDur[4][1] = 5;
        nHalf[4][2] = 11; nDur[4][2] = 20;
        nHalf[5][0] = 5;  nDur[5][0] = 10;
        nHalf[5][1] = 4;  nDur[5][1] = 10;
        nHalf[5][2] = 3;  nDur[5][2] = 10;
        nHalf[5][3] = 2;  nDur[5][3] = 30;
        nHalf[6][0] = 5;  nDur[6][0] = 15;
        nHalf[6][1] = 7;  nDur[6][1] = 15;
        nHalf[6][2] = 11; nDur[6][2] = 40;

        vecs[0] = '{3'd0, 0, 3'd0, 2};
        vecs[1] = '{3'd2, 0, 3'd0, 125};
        vecs[2] = '{3'd4, 0, 3'd0, 145};
        vecs[3] = '{3'd1, 0, 3'd0, 23};
        vecs[4] = '{3'd3, 0, 3'd0, 124};
        vecs[5] = '{3'd5, 0, 3'd0, 246};
        vecs[6] = '{3'd6, 0, 3'd0, 285};
        vecs[7] = '{3'd7, 0, 3'd0, 2};
        vecs[8] = '{3'd6, 30, 3'd1, 23};

        bif.start = 1'b0;
        bif.sel   = 3'd0;

        // Reset held, with a start request that must be ignored.
        @(negedge clk);
        checkCycle("in_reset", '0);
        bif.start = 1'b1;
        bif.sel   = 3'd2;
        @(negedge clk);
        checkCycle("start_in_reset", '0);
        bif.start = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checkCycle($sformatf("idle%0d", k), '0);
        end

        foreach (vecs[i]) runVec(vecs[i]);

        // Reset mid sel=5: abort immediately, then sel=3 must play normally.
        pushSeq(5, 50);
        @(negedge clk);
        bif.start = 1'b1;
        bif.sel   = 3'd5;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            checkCycle($sformatf("sel5_pre_rst cyc%0d", j), expQ.pop_front());
            bif.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1 checkCycle("async_rst", '0);
        bif.start = 1'b1;
        bif.sel   = 3'd4;
        @(negedge clk);
        checkCycle("rst_held", '0);
        bif.start = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkCycle($sformatf("post_rst_idle%0d", k), '0);
        end
        runVec('{3'd3, 0, 3'd0, 124});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
